// File: rtl/param_regfile_alu_seq_if.sv
// Command/status bundle for param_regfile_alu_seq: strobes and operand input
// from the button logic, result and flags back to the display/LED logic.
interface param_regfile_alu_seq_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in;
  logic              op;
  logic              rr1_wr;
  logic              rr2_wd;
  logic              we;
  logic [DATA_W-1:0] result;
  logic              cf;
  logic              zf;
  logic              sf;
  logic              vf;
  logic              done;
  logic              err;
  logic [1:0]        state;

  modport master (
    output in, op, rr1_wr, rr2_wd, we,
    input  result, cf, zf, sf, vf, done, err, state
  );

  modport slave (
    input  in, op, rr1_wr, rr2_wd, we,
    output result, cf, zf, sf, vf, done, err, state
  );
endinterface

// File: rtl/param_regfile_alu_seq.sv
// Button-driven register-file ALU: synchronised strobes step a sequencer through
// opcode, operand A, operand B (with result preview) and write-back.
module param_regfile_alu_seq #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  param_regfile_alu_seq_if.slave bus
);
  localparam int RA_W  = $clog2(NREGS);
  localparam int EXT_W = (DATA_W > 4) ? DATA_W : 4;

  typedef enum logic [1:0] {S_OP = 2'd0, S_A = 2'd1, S_B = 2'd2, S_EX = 2'd3} state_t;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_LDI = 4'd4,
    OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7, OP_SHL = 4'd8, OP_SHR = 4'd9
  } opcode_t;

  // Bit order everywhere: [0] op, [1] rr1_wr, [2] rr2_wd, [3] we
  logic [3:0] raw, sync1, sync2, prev, ev;
  assign raw = {bus.we, bus.rr2_wd, bus.rr1_wr, bus.op};

  // Flops reset high so a strobe already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end
  assign ev = sync2 & ~prev;

  state_t            state_q, state_d;
  opcode_t           opcode_q, opcode_d;
  logic [RA_W-1:0]   a_idx_q, a_idx_d;
  logic              err_q, err_d, done_q, done_d;
  logic              load_res, wr_en;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] result_q;
  logic              cf_q, zf_q, sf_q, vf_q;

  logic [EXT_W-1:0]  in_ext;
  logic              op_legal, multi_ev;
  assign in_ext   = EXT_W'(bus.in);
  assign op_legal = (in_ext[3:0] <= 4'd9) && ((in_ext >> 4) == '0);
  assign multi_ev = |(ev & (ev - 4'd1));

  // op outranks every other simultaneous event; any other collision is an error
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_idx_d  = a_idx_q;
    err_d    = err_q;
    done_d   = 1'b0;
    load_res = 1'b0;
    wr_en    = 1'b0;
    if (ev[0]) begin
      opcode_d = opcode_t'(in_ext[3:0]);
      err_d    = !op_legal;
      state_d  = op_legal ? S_A : S_OP;
    end else if (multi_ev) begin
      err_d = 1'b1;
    end else if (ev[1] && state_q == S_A) begin
      a_idx_d = bus.in[RA_W-1:0];
      state_d = S_B;
    end else if (ev[2] && state_q == S_B) begin
      load_res = 1'b1;
      state_d  = S_EX;
    end else if (ev[3] && state_q == S_EX) begin
      wr_en   = (opcode_q != OP_NOP);
      done_d  = 1'b1;
      state_d = S_OP;
    end else if (ev != '0) begin
      err_d = 1'b1;
    end
  end

  logic [DATA_W-1:0] a_val, b_val, alu_res;
  logic [DATA_W:0]   sum;
  logic              alu_cf, alu_vf;
  assign a_val = regs[a_idx_q];
  assign b_val = (opcode_q == OP_LDI) ? bus.in : regs[bus.in[RA_W-1:0]];
  assign sum   = {1'b0, a_val} + {1'b0, b_val};

  always_comb begin
    alu_res = a_val;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        {alu_cf, alu_res} = sum;
        alu_vf = (a_val[DATA_W-1] == b_val[DATA_W-1]) && (sum[DATA_W-1] != a_val[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = a_val - b_val;
        alu_cf  = (a_val < b_val);
        alu_vf  = (a_val[DATA_W-1] != b_val[DATA_W-1]) && (alu_res[DATA_W-1] != a_val[DATA_W-1]);
      end
      OP_AND: alu_res = a_val & b_val;
      OP_OR:  alu_res = a_val | b_val;
      OP_XOR: alu_res = a_val ^ b_val;
      OP_NOT: alu_res = ~a_val;
      OP_LDI: alu_res = b_val;
      OP_SHL: {alu_cf, alu_res} = {a_val, 1'b0};
      OP_SHR: {alu_res, alu_cf} = {1'b0, a_val};
      default: alu_res = a_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OP;
      opcode_q <= OP_NOP;
      a_idx_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_idx_q  <= a_idx_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      vf_q     <= 1'b0;
    end else begin
      if (wr_en) regs[a_idx_q] <= result_q;
      if (load_res) begin
        result_q <= alu_res;
        cf_q     <= alu_cf;
        zf_q     <= (alu_res == '0);
        sf_q     <= alu_res[DATA_W-1];
        vf_q     <= alu_vf;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.cf     = cf_q;
  assign bus.zf     = zf_q;
  assign bus.sf     = sf_q;
  assign bus.vf     = vf_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.state  = state_q;
endmodule
